// File: rtl/freq_div_ctrl.sv
// rtl/freq_div_ctrl.sv - programmable tick-enable scheduler with burst mode and boundary-aligned reconfiguration
module freq_div_ctrl #(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_burst,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             start,
    input  logic             stop,
    output logic             tick,
    output logic             div_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cur_div
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ZERO = '0;
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DEF  = CNT_W'(DEF_DIV);

    state_t           state;
    state_t           state_nx;
    logic             done_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] rem;
    logic             mode;
    logic             pend_valid;
    logic [CNT_W-1:0] pend_div;
    logic             pend_burst;
    logic [CNT_W-1:0] pend_len;
    logic             cfg_fire;
    logic             go;
    logic [CNT_W-1:0] cfg_div_c;
    logic [CNT_W-1:0] cfg_len_c;

    assign busy      = (state != IDLE);
    assign tick      = busy && (cnt == cur_div - ONE);
    assign cfg_ready = (state == IDLE) || !pend_valid;
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign go        = start && !stop;
    assign cfg_div_c = (cfg_div == ZERO) ? ONE : cfg_div;
    assign cfg_len_c = (cfg_len == ZERO) ? ONE : cfg_len;

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (go)
                    state_nx = RUN;
            end
            RUN: begin
                // Burst end wins over a coincident stop so only one done pulse is produced.
                if (tick && mode && (rem == ONE)) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else if (stop) begin
                    state_nx = STOPPING;
                end
            end
            STOPPING: begin
                if (tick) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            done       <= 1'b0;
            cnt        <= ZERO;
            div_out    <= 1'b0;
            cur_div    <= DEF;
            mode       <= 1'b0;
            len        <= ONE;
            rem        <= ONE;
            pend_valid <= 1'b0;
            pend_div   <= ONE;
            pend_burst <= 1'b0;
            pend_len   <= ONE;
        end else begin
            state <= state_nx;
            done  <= done_nx;
            if (state == IDLE) begin
                cnt <= ZERO;
                if (cfg_fire) begin
                    cur_div <= cfg_div_c;
                    mode    <= cfg_burst;
                    len     <= cfg_len_c;
                end
                if (go)
                    rem <= cfg_fire ? cfg_len_c : len;
            end else begin
                cnt <= tick ? ZERO : cnt + ONE;
                if (tick) begin
                    div_out <= ~div_out;
                    if (mode)
                        rem <= rem - ONE;
                    // Pending config takes effect exactly at the period boundary.
                    if (pend_valid) begin
                        cur_div    <= pend_div;
                        mode       <= pend_burst;
                        len        <= pend_len;
                        pend_valid <= 1'b0;
                    end
                end
                if (cfg_fire) begin
                    pend_div   <= cfg_div_c;
                    pend_burst <= cfg_burst;
                    pend_len   <= cfg_len_c;
                    pend_valid <= 1'b1;
                end
            end
        end
    end

endmodule
